// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
//
// Steps an LED pattern once per rising edge of an externally divided slow
// clock. The slow clock is treated as an asynchronous data input and is
// synchronised into clk before its edges are used.
//
// Patterns (mode):
//   00 SHIFT  : rotating single lit LED, 1 -> 2 -> .. -> MSB -> 1 (wrap)
//   01 BOUNCE : single lit LED sweeping up then down, 1 .. MSB .. 1 (wrap)
//   10 COUNT  : binary up-counter, all-ones -> 0 (wrap)
//   11 FILL   : thermometer fill, 0 -> 1 -> 3 -> .. -> all-ones -> 0 (wrap)
//
// Ports:
//   clk       system clock, all state changes on its rising edge
//   rst_n     asynchronous active-low reset
//   slow_clk  divided square wave, asynchronous to clk; one step per rise
//   mode      pattern select, sampled only on an accepted step
//   pause     high = hold the pattern; steps arriving while high are dropped
//   led       registered LED drive, bit 0 = LED0
//   wrap      registered one-cycle pulse when a pattern cycle completes
//
// State table (pattern controller):
//   state    | meaning
//   DIR_UP   | BOUNCE lit bit moving toward the MSB; idle value in other modes
//   DIR_DOWN | BOUNCE lit bit moving back toward bit 0
//   mode_q   | pattern currently running; changes only on an accepted step
// -----------------------------------------------------------------------------
module led_pattern_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_clk,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [WIDTH-1:0] led,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_COUNT  = 2'b10,
    MODE_FILL   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MSB_ONLY = ONE << (WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic is_one_hot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  // Thermometer codes (including 0 and all-ones) have no set bit above a
  // clear bit, so adding one carries through every set bit.
  function automatic logic is_thermo(input logic [WIDTH-1:0] v);
    return (v & (v + ONE)) == '0;
  endfunction

  function automatic logic [WIDTH-1:0] start_pattern(input mode_e m);
    case (m)
      MODE_SHIFT, MODE_BOUNCE: return ONE;
      default:                 return '0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // slow_clk synchroniser and rising-edge detect
  // ---------------------------------------------------------------------------
  logic       s1;
  logic       s2;
  logic       s3;
  logic       armed;
  logic [1:0] sync_fill;
  logic       tick;
  logic       accept;

  // s2 only carries a genuine slow_clk sample once two clk edges have filled
  // the synchroniser after reset; before that its reset 0 would arm the
  // block even with slow_clk held high, and the first real high sample would
  // then look like a fresh edge. sync_fill holds off arming until s2 is real.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      armed     <= 1'b0;
      sync_fill <= 2'd0;
    end else begin
      s1 <= slow_clk;
      s2 <= s1;
      s3 <= s2;
      if (sync_fill != 2'd2) begin
        sync_fill <= sync_fill + 2'd1;
      end
      if ((sync_fill == 2'd2) && !s2) begin
        armed <= 1'b1;
      end
    end
  end

  assign tick   = s2 & ~s3;
  assign accept = tick & armed & ~pause;

  // ---------------------------------------------------------------------------
  // Pattern controller
  // ---------------------------------------------------------------------------
  mode_e            mode_q;
  mode_e            mode_nxt;
  mode_e            mode_in;
  dir_e             dir;
  dir_e             dir_nxt;
  logic [WIDTH-1:0] led_nxt;
  logic             wrap_nxt;
  logic [WIDTH-1:0] led_shl;
  logic [WIDTH-1:0] led_shr;

  assign led_shl = led << 1;
  assign led_shr = led >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led    <= ONE;
      wrap   <= 1'b0;
      mode_q <= MODE_SHIFT;
      dir    <= DIR_UP;
    end else begin
      led    <= led_nxt;
      wrap   <= wrap_nxt;
      mode_q <= mode_nxt;
      dir    <= dir_nxt;
    end
  end

  always_comb begin
    led_nxt  = led;
    wrap_nxt = 1'b0;
    mode_nxt = mode_q;
    dir_nxt  = dir;
    mode_in  = mode_e'(mode);

    if (accept) begin
      if (mode_in != mode_q) begin
        // A mode switch consumes the step: load the new start pattern only.
        mode_nxt = mode_in;
        led_nxt  = start_pattern(mode_in);
        dir_nxt  = DIR_UP;
      end else begin
        case (mode_q)
          MODE_SHIFT: begin
            if (!is_one_hot(led)) begin
              led_nxt = ONE;
            end else if (led == MSB_ONLY) begin
              led_nxt  = ONE;
              wrap_nxt = 1'b1;
            end else begin
              led_nxt = led_shl;
            end
          end

          MODE_BOUNCE: begin
            if (!is_one_hot(led)) begin
              led_nxt = ONE;
              dir_nxt = DIR_UP;
            end else if (dir == DIR_UP) begin
              if (led == MSB_ONLY) begin
                // Already at the top while still marked up: turn around.
                led_nxt = led_shr;
                dir_nxt = DIR_DOWN;
              end else begin
                led_nxt = led_shl;
                if (led_shl == MSB_ONLY) begin
                  dir_nxt = DIR_DOWN;
                end
              end
            end else begin
              if (led == ONE) begin
                // Already at the bottom while still marked down: turn around.
                led_nxt = led_shl;
                dir_nxt = DIR_UP;
              end else begin
                led_nxt = led_shr;
                if (led_shr == ONE) begin
                  dir_nxt  = DIR_UP;
                  wrap_nxt = 1'b1;
                end
              end
            end
          end

          MODE_COUNT: begin
            led_nxt  = led + ONE;
            wrap_nxt = (led == ALL_ONES);
          end

          MODE_FILL: begin
            if (!is_thermo(led)) begin
              led_nxt = '0;
            end else if (led == ALL_ONES) begin
              led_nxt  = '0;
              wrap_nxt = 1'b1;
            end else begin
              led_nxt = led_shl | ONE;
            end
          end

          default: begin
            led_nxt = start_pattern(mode_q);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         slow_clk;
  logic [1:0]   mode;
  logic         pause;
  logic [W-1:0] led;
  logic         wrap;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [W-1:0] led;
    logic         wrap;
  } exp_t;

  exp_t sb[$];

  led_pattern_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .slow_clk (slow_clk),
    .mode     (mode),
    .pause    (pause),
    .led      (led),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One slow_clk pulse rising just after clk edge N. The expected result is
  // queued when the edge is driven and compared after edge N+3; wrap must be
  // low again one cycle later.
  task automatic step(input string tag, input logic [W-1:0] e_led, input logic e_wrap);
    exp_t e;
    e.led  = e_led;
    e.wrap = e_wrap;
    sb.push_back(e);
    @(posedge clk);
    #1 slow_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_led"}, 32'(led), 32'(e.led));
      chk({tag, "_wrap"}, 32'(wrap), 32'(e.wrap));
    end
    slow_clk = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_wrap_fall"}, 32'(wrap), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  logic [W-1:0] bnc_seq [14];

  initial begin
    exp_t e;
    bnc_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    rst_n    = 1'b1;
    slow_clk = 1'b0;
    mode     = 2'b00;
    pause    = 1'b0;

    // Reset takes effect without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("reset_led_async", 32'(led), 32'h01);
    chk("reset_wrap_async", 32'(wrap), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led_hold", 32'(led), 32'h01);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // SHIFT from reset: 02,04,..,80,01,02 with wrap on 80 -> 01.
    mode = 2'b00;
    for (int i = 0; i < 9; i++) begin
      step($sformatf("shift%0d", i), 8'(1 << ((i + 1) % 8)), (i == 7));
    end

    // Mode wiggled between steps is not sampled.
    @(posedge clk);
    #1 mode = 2'b10;
    repeat (2) @(posedge clk);
    #1 mode = 2'b00;
    step("mode_between_steps", 8'h04, 1'b0);

    // BOUNCE: first step loads 01, then a full sweep with wrap on 02 -> 01.
    mode = 2'b01;
    step("bnc_load", 8'h01, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step($sformatf("bnc%0d", i), bnc_seq[i], (i == 13));
    end

    // COUNT up to 5A, then asynchronous reset between clk edges.
    mode = 2'b10;
    step("cnt_load", 8'h00, 1'b0);
    for (int i = 1; i <= 'h5a; i++) begin
      step($sformatf("cnt%0d", i), 8'(i), 1'b0);
    end
    @(posedge clk);
    #1;
    chk("cnt_pre_reset", 32'(led), 32'h5a);
    #2 rst_n = 1'b0;
    #1;
    chk("midcount_reset_led", 32'(led), 32'h01);
    chk("midcount_reset_wrap", 32'(wrap), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // COUNT from reset: load 00, preload FE, then FF and 00 with wrap.
    step("cnt2_load", 8'h00, 1'b0);
    for (int i = 1; i <= 'hfe; i++) begin
      step($sformatf("cnt2_%0d", i), 8'(i), 1'b0);
    end
    step("cnt_ff", 8'hff, 1'b0);
    step("cnt_wrap", 8'h00, 1'b1);

    // FILL: load 00, then 01,03,..,FF, then 00 with wrap.
    mode = 2'b11;
    step("fill_load", 8'h00, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step($sformatf("fill%0d", k), 8'((1 << k) - 1), 1'b0);
    end
    step("fill_wrap", 8'h00, 1'b1);

    // Pause across three steps while mode is toggled.
    pause = 1'b1;
    step("pause0", 8'h00, 1'b0);
    mode = 2'b00;
    step("pause1", 8'h00, 1'b0);
    mode = 2'b01;
    step("pause2", 8'h00, 1'b0);
    mode  = 2'b00;
    pause = 1'b0;
    step("unpause_load", 8'h01, 1'b0);
    step("unpause_adv", 8'h02, 1'b0);

    // slow_clk held high through reset release: no step until low then high.
    @(posedge clk);
    #1 slow_clk = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("high_release_led", 32'(led), 32'h01);
    chk("high_release_wrap", 32'(wrap), 32'd0);
    slow_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("high_release_low_led", 32'(led), 32'h01);

    // Edge-to-led latency: unchanged after edge N+2, stepped after N+3.
    e.led  = 8'h02;
    e.wrap = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1 slow_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("latency_n2_led", 32'(led), 32'h01);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("latency_n3_led", 32'(led), 32'(e.led));
    chk("latency_n3_wrap", 32'(wrap), 32'(e.wrap));
    slow_clk = 1'b0;
    repeat (4) @(posedge clk);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_pattern_sequencer.md
LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 8, LED count; legal range 2..32.
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: slow_clk  input  1  divided square wave from the upstream counter-based divider; asynchronous to clk logic, one step per rising edge.
REQ-005 SHALL have port: mode  input  2  pattern select: 00 SHIFT, 01 BOUNCE, 10 COUNT, 11 FILL.
REQ-006 SHALL have port: pause  input  1  high = hold pattern, ignore steps.
REQ-007 SHALL have port: led  output  WIDTH  registered LED drive, bit 0 = LED0.
REQ-008 SHALL have port: wrap  output  1  registered one-cycle pulse on pattern cycle completion.

Function
REQ-009 SHALL pass slow_clk through 2 flops (s1, s2) and then a history flop (s3); tick = s2 & ~s3.
REQ-010 SHALL keep an armed flag, cleared by reset and set on the first clk edge where s2 = 0; tick SHALL be ignored while not armed (no spurious step if slow_clk is high at reset release).
REQ-011 Latency: slow_clk high at clk edge N -> tick high in cycle N+2 -> led/wrap update at edge N+3.
REQ-012 Tick with pause = 1: led, wrap, direction and stored mode unchanged; the tick is discarded, not queued.
REQ-013 mode SHALL be sampled only on an accepted tick (tick & armed & ~pause) into mode_q; mode changes between ticks have no effect.
REQ-014 Accepted tick with mode != mode_q: mode_q <= mode, led <= start pattern of the new mode, dir <= up, wrap <= 0; no advance on that tick.
REQ-015 Start patterns: SHIFT 1, BOUNCE 1, COUNT 0, FILL 0.
REQ-016 SHIFT: rotate left by 1; MSB-only wraps to 1 with wrap = 1.
REQ-017 BOUNCE: one-hot; dir up shifts left, dir down shifts right; reaching the MSB sets dir down; reaching bit 0 while going down sets dir up with wrap = 1 (sequence 1,2,..,MSB,..,2,1; no repeated end states).
REQ-018 COUNT: led + 1 modulo 2^WIDTH; all-ones -> 0 with wrap = 1.
REQ-019 FILL: led <= (led << 1) | 1; all-ones -> 0 with wrap = 1.
REQ-020 Non-legal led value at a tick (non-one-hot in SHIFT/BOUNCE, non-thermometer in FILL) SHALL reload the mode start pattern, with wrap = 0.
REQ-021 wrap SHALL be high exactly one clk cycle and only in the cycle after the wrapping edge; it is 0 on all other edges.
REQ-022 Two slow_clk rising edges closer than 3 clk cycles need not both be counted; the block SHALL NOT double-step on one edge.

Reset
REQ-023 rst_n low SHALL immediately force led = 1, wrap = 0, mode_q = 00, dir = up, s1 = s2 = s3 = 0, armed = 0.
REQ-024 Reset asserted mid-pattern SHALL abandon the pattern; after release, the first accepted tick acts per REQ-013..020 from the reset state.

Verification
REQ-025 Scenario: mode = 00, 9 slow_clk rising edges -> led = 02,04,08,10,20,40,80,01,02; wrap pulses once, at the 80 -> 01 step.
REQ-026 Scenario: mode = 01 from reset -> first tick loads 01, no wrap; next 14 ticks -> 02..80..01; wrap once, at the final 02 -> 01.
REQ-027 Scenario: mode = 10 preloaded to FE via ticks -> next ticks give FF, then 00 with wrap = 1; FILL gives 00,01,03,...,FF,00 with wrap at FF -> 00.
REQ-028 Scenario: pause = 1 across 3 slow_clk edges -> led and wrap constant; mode toggled during pause is not adopted until the first tick after pause = 0.
REQ-029 Scenario: slow_clk held high through reset release -> no step until slow_clk goes low then high again; check the edge-to-led latency is exactly 3 clk.
REQ-030 Scenario: rst_n pulsed low asynchronously between clk edges mid-COUNT (led = 5A) -> led = 01 and wrap = 0 before the next clk edge.
